// File: rtl/xxd_pkg.sv
// Shared types and constants for the xxd hex-dump line sequencer.
// Holds the FSM state type, buffer mux selects and the pad byte.
package xxd_pkg;

  typedef enum logic [1:0] {
    FILL,
    ALIGN,
    DRAIN
  } seq_state_t;

  localparam logic       SRC_IN  = 1'b0;
  localparam logic       SRC_PAD = 1'b1;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  localparam int XXD_DEPTH_DEF = 64;

endpackage

// File: rtl/xxd_offset_counter.sv
// Wrapping W-bit byte-offset counter with increment enable.
// Ports: clk, rst_n (async low), inc_i, cnt_o[W-1:0].
module xxd_offset_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/xxd_shift_sequencer.sv
// Fill/align/drain controller for a DEPTH-byte shift buffer line.
// Ports: clk, rst_n, in_valid/in_ready, flush, buf_shift_en,
// buf_src_sel, out_valid/out_ready, out_last, out_pad, line_offset.
// Option: XXD_SEQ_PAD_OUT_EN emits leading pads instead of aligning.
module xxd_shift_sequencer
  import xxd_pkg::*;
#(
  parameter int DEPTH  = XXD_DEPTH_DEF,
  parameter int OFFS_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              buf_shift_en,
  output logic              buf_src_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_pad,
  output logic [OFFS_W-1:0] line_offset
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  seq_state_t    state_q;
  logic [CW-1:0] fill_cnt_q;
  logic [CW-1:0] rem_cnt_q;
  logic [CW-1:0] pad_cnt_q;
  logic [CW-1:0] fill_d;
  logic          accept;
  logic          drain_go;

  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    buf_shift_en = 1'b0;
    buf_src_sel  = SRC_IN;
    unique case (state_q)
      FILL: begin
        // held low while reset is asserted
        in_ready     = rst_n;
        buf_shift_en = in_valid & rst_n;
      end
      ALIGN: begin
        buf_shift_en = 1'b1;
        buf_src_sel  = SRC_PAD;
      end
      DRAIN: begin
        out_valid    = 1'b1;
        out_last     = (rem_cnt_q == ONE_C);
        buf_shift_en = out_ready;
        buf_src_sel  = SRC_PAD;
      end
      default: ;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign fill_d   = fill_cnt_q + {{(CW-1){1'b0}}, accept};
  assign drain_go = out_valid & out_ready;

`ifdef XXD_SEQ_PAD_OUT_EN
  // pad_cnt counts the leading pads still to be emitted
  assign out_pad = out_valid & (pad_cnt_q != '0);
`else
  assign out_pad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      rem_cnt_q  <= '0;
      pad_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (fill_d == DEPTH_C) begin
            state_q    <= DRAIN;
            rem_cnt_q  <= DEPTH_C;
            pad_cnt_q  <= '0;
            fill_cnt_q <= '0;
          end else if (flush && fill_d != '0) begin
`ifdef XXD_SEQ_PAD_OUT_EN
            state_q    <= DRAIN;
            rem_cnt_q  <= DEPTH_C;
`else
            state_q    <= ALIGN;
            rem_cnt_q  <= fill_d;
`endif
            pad_cnt_q  <= DEPTH_C - fill_d;
            fill_cnt_q <= '0;
          end else begin
            fill_cnt_q <= fill_d;
          end
        end
        ALIGN: begin
          pad_cnt_q <= pad_cnt_q - ONE_C;
          if (pad_cnt_q == ONE_C) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            rem_cnt_q <= rem_cnt_q - ONE_C;
            if (pad_cnt_q != '0) begin
              pad_cnt_q <= pad_cnt_q - ONE_C;
            end
            if (rem_cnt_q == ONE_C) begin
              state_q <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  xxd_offset_counter #(
    .W(OFFS_W)
  ) u_offs (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(drain_go),
    .cnt_o(line_offset)
  );

endmodule

// File: tb/tb_xxd_shift_sequencer.sv
// Self-checking bench: 4-stage shift buffer around the sequencer,
// queue-based line model, directed cases then random traffic.
module tb_xxd_shift_sequencer;
  import xxd_pkg::*;

  localparam int DEPTH  = 4;
  localparam int OFFS_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              buf_shift_en;
  logic              buf_src_sel;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              out_pad;
  logic [OFFS_W-1:0] line_offset;
  logic [7:0]        sb [DEPTH];
  logic [7:0]        out_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         pad;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] line_q[$];
  int         align_left = 0;
  int         off_m = 0;

  always #5 clk = ~clk;

  xxd_shift_sequencer #(
    .DEPTH (DEPTH),
    .OFFS_W(OFFS_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .buf_shift_en(buf_shift_en),
    .buf_src_sel (buf_src_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_pad     (out_pad),
    .line_offset (line_offset)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= 8'h00;
    end else if (buf_shift_en) begin
      sb[0] <= (buf_src_sel == SRC_PAD) ? PAD_BYTE : in_data;
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  assign out_data = sb[DEPTH-1];

  task automatic expect_eq(string tag, logic [31:0] got,
                           logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Close the current line: queue what the consumer must see.
  task automatic emit_line();
    int pads;
    ent_t e;
    pads = DEPTH - line_q.size();
`ifdef XXD_SEQ_PAD_OUT_EN
    for (int i = 0; i < pads; i++) begin
      e.d = 8'h00; e.last = 1'b0; e.pad = 1'b1;
      exp_q.push_back(e);
    end
    align_left = 0;
`else
    align_left = pads;
`endif
    foreach (line_q[i]) begin
      e.d = line_q[i];
      e.last = (i == line_q.size() - 1);
      e.pad = 1'b0;
      exp_q.push_back(e);
    end
    line_q.delete();
  endtask

  task automatic step(bit iv, logic [7:0] d, bit fl, bit ordy);
    bit idle, acc, drn, zero;
    @(negedge clk);
    in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
    #1;
    idle = (exp_q.size() == 0) && (align_left == 0);
    drn  = (exp_q.size() != 0) && (align_left == 0);
    acc  = iv && idle;
    expect_eq("in_ready", 32'(in_ready), 32'(idle));
    expect_eq("out_valid", 32'(out_valid), 32'(drn));
    expect_eq("shift_en", 32'(buf_shift_en),
              32'(acc || align_left > 0 || (drn && ordy)));
    if (align_left > 0 || (drn && ordy))
      expect_eq("src_pad", 32'(buf_src_sel), 32'(SRC_PAD));
    if (acc)
      expect_eq("src_in", 32'(buf_src_sel), 32'(SRC_IN));
    if (drn) begin
      expect_eq("out_data", 32'(out_data), 32'(exp_q[0].d));
      expect_eq("out_last", 32'(out_last), 32'(exp_q[0].last));
      expect_eq("out_pad", 32'(out_pad), 32'(exp_q[0].pad));
      expect_eq("offset", 32'(line_offset), 32'(off_m));
    end
    if (idle && line_q.size() == 0) begin
      zero = 1'b1;
      for (int i = 0; i < DEPTH; i++) if (sb[i] !== 8'h00) zero = 1'b0;
      expect_eq("buf_zero", 32'(zero), 32'd1);
    end
    if (drn && ordy) begin
      void'(exp_q.pop_front());
      off_m = (off_m + 1) % (1 << OFFS_W);
    end
    if (align_left > 0) align_left--;
    if (acc) line_q.push_back(d);
    if (idle) begin
      if (line_q.size() == DEPTH) emit_line();
      else if (fl && line_q.size() > 0) emit_line();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
    expect_eq("rst_in_ready", 32'(in_ready), 32'd0);
    expect_eq("rst_shift_en", 32'(buf_shift_en), 32'd0);
    expect_eq("rst_last", 32'(out_last), 32'd0);
    expect_eq("rst_pad", 32'(out_pad), 32'd0);
    expect_eq("rst_offset", 32'(line_offset), 32'd0);
    exp_q.delete(); line_q.delete();
    align_left = 0; off_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_eq("rel_in_ready", 32'(in_ready), 32'd1);
    expect_eq("rel_offset", 32'(line_offset), 32'd0);
  endtask

  task automatic idle_steps(int n, bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, ordy);
  endtask

  task automatic full_line(logic [7:0] b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, b0 + 8'(i), 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();
    // straight full line
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    idle_steps(5, 1'b1);
    // partial line then flush
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle_steps(6, 1'b1);
    // byte and flush together, then a flush on an empty line
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    step(1'b1, 8'h5B, 1'b0, 1'b1);
    step(1'b1, 8'h5C, 1'b1, 1'b1);
    idle_steps(6, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle_steps(2, 1'b1);
    // consumer backpressure
    full_line(8'hC0);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b0, (i % 4) == 0 || (i % 4) == 3);
    idle_steps(2, 1'b1);
    // reset after one of four bytes drained
    full_line(8'hD0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    do_reset();
    // enough full lines to wrap the offset
    for (int l = 0; l < 5; l++) begin
      full_line(8'(8'h10 * l));
      idle_steps(DEPTH, 1'b1);
    end
    idle_steps(1, 1'b1);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end
    idle_steps(3 * DEPTH, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xxd_shift_sequencer.md
Name: xxd_shift_sequencer

Overview:
- Controller that sequences a DEPTH-byte shift-buffer datapath. The buffer is an 8-bit-wide shift chain; its oldest byte sits at the top stage and drives the consumer directly.
- Fill phase: accepts bytes from a valid/ready producer until the line is full or a flush is requested.
- Partial lines: pads them so the oldest real byte reaches the top.
- Drain phase: drains bytes to a valid/ready consumer, tagging each with a running byte offset for the hex-dump formatter downstream.

Parameters:
- DEPTH, 64, bytes per line / shift-buffer stages; must be >= 2.
- OFFS_W, 16, width of the running byte-offset counter; wraps modulo 2^OFFS_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low; also drives the shift buffer
- in_valid  in  1  producer byte valid
- in_ready  out  1  controller accepts a byte this cycle
- flush  in  1  close the current partial line (level-sampled, single-cycle pulse expected)
- buf_shift_en  out  1  shift buffer advances one stage this cycle
- buf_src_sel  out  1  buffer input mux: 0 = producer byte, 1 = pad byte 0x00
- out_valid  out  1  top buffer stage holds a byte for the consumer
- out_ready  in  1  consumer takes the byte
- out_last  out  1  current out byte is the last of the line
- out_pad  out  1  current out byte is padding (feature-dependent, else 0)
- line_offset  out  OFFS_W  byte offset of the current out byte

Behaviour:
- States: FILL, ALIGN, DRAIN.
- Registers: fill_cnt (0..DEPTH), rem_cnt (0..DEPTH), pad_cnt (0..DEPTH), offset (OFFS_W).
- Reset: state=FILL, all counters 0.
  - in_ready=0 while rst_n low, 1 from the first cycle after release.
  - All other outputs 0.
- FILL:
  - in_ready=1.
  - On an accept (in_valid&in_ready): buf_shift_en=1, buf_src_sel=0, fill_cnt+1.
  - Let n = fill_cnt including any byte accepted this cycle.
  - If n==DEPTH: next=DRAIN, rem_cnt=DEPTH, fill_cnt=0. Flush in that cycle is a no-op.
  - Else if flush and n>0: next=ALIGN, pad_cnt=DEPTH-n, rem_cnt=n, fill_cnt=0.
  - Else if flush and n==0: flush ignored, stay FILL.
  - A byte and a flush in the same cycle both take effect; the byte counts in n.
- ALIGN:
  - in_ready=0, out_valid=0.
  - Every cycle: buf_shift_en=1, buf_src_sel=1, pad_cnt-1.
  - When pad_cnt==1: next=DRAIN. Duration is exactly DEPTH-n cycles.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_last = (rem_cnt==1).
  - On out_ready: buf_shift_en=1, buf_src_sel=1, rem_cnt-1, offset+1 (wraps).
  - On out_ready with out_last: next=FILL.
- out_valid must stay asserted and the top byte stable until accepted; there is no drop or retract.
- Latency: first out_valid appears 1 cycle after the DEPTH-th accept, or DEPTH-n+1 cycles after a partial flush.
- buf_shift_en is 0 whenever no rule above asserts it. Outputs are combinational from state/registers plus the handshakes.
- line_offset = offset register. It is never cleared except by reset.
- rst_n asserted mid-operation: controller and buffer clear together; any partial line is discarded; no out_valid glitch.
- After every drain the buffer holds all 0x00.

Optional Feature:
- Macro: XXD_SEQ_PAD_OUT_EN.
- Defined:
  - A partial flush skips ALIGN and goes straight to DRAIN with rem_cnt=DEPTH.
  - The first DEPTH-n drained bytes are leading pads (0x00) and carry out_pad=1.
  - Pad bytes increment line_offset like real bytes.
- Undefined:
  - ALIGN path as above; only the n real bytes are emitted.
  - out_pad tied 0.

Decomposition:
- Package xxd_pkg holds:
  - state typedef seq_state_t {FILL, ALIGN, DRAIN}
  - constants SRC_IN=1'b0, SRC_PAD=1'b1, PAD_BYTE=8'h00
  - default DEPTH=64
- One natural sub-module: xxd_offset_counter, an OFFS_W wrapping counter with increment enable and async reset, reused by the formatter.

Test Plan (DEPTH=4 unless noted; bench instantiates a 4-stage shift buffer):
- Stream 8'h11,22,33,44 with out_ready=1 -> out bytes 11,22,33,44; out_last on 44; line_offset 0..3; in_ready=0 during drain; buffer all 00 afterwards.
- Send 8'hA1,A2 then flush -> 2 ALIGN cycles (shift_en=1, src_sel=1, out_valid=0), then out A1 (offset 4), A2 (offset 5, out_last); with PAD_OUT_EN -> 00,00 (out_pad=1), A1, A2.
- in_valid with byte 8'h5C and flush in the same cycle after 2 prior bytes -> n=3, 1 ALIGN cycle, 3 bytes drained; flush with fill_cnt=0 -> no state change.
- Backpressure: full line with out_ready toggling 1,0,0,1,... -> no shift while out_ready=0; bytes stable; order preserved; line_offset unchanged on stalls.
- Assert rst_n low mid-DRAIN after 1 of 4 bytes -> out_valid=0 immediately; after release state FILL, in_ready=1, line_offset=0.
- OFFS_W=4: drain 5 full lines -> line_offset wraps 15->0 at byte 16.
